// File: rtl/vga_tri_pkg.sv
// Shared constants, field encodings and edge-arithmetic helpers for the triangle rasteriser.
package vga_tri_pkg;

  localparam int CX_W = 11;
  localparam int CY_W = 10;
  localparam int OP_W = 12;
  localparam int E_W  = 25;

  localparam int DEF_H_TOTAL     = 1586;
  localparam int DEF_H_SYNC      = 190;
  localparam int DEF_H_ACT_START = 285;
  localparam int DEF_H_ACT_END   = 1555;
  localparam int DEF_V_TOTAL     = 526;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_ACT_START = 35;
  localparam int DEF_V_ACT_END   = 515;

  typedef enum logic [1:0] {
    FLD_V0  = 2'd0,
    FLD_V1  = 2'd1,
    FLD_V2  = 2'd2,
    FLD_COL = 2'd3
  } cfg_field_e;

  typedef struct packed {
    logic [CX_W-1:0] x;
    logic [CY_W-1:0] y;
  } vtx_t;

  typedef struct packed {
    vtx_t [2:0]  v;
    logic [11:0] rgb;
    logic        en;
  } tri_t;

  // Coordinates are unsigned; a zero top bit makes them non-negative signed operands.
  function automatic logic signed [OP_W-1:0] ext_x(input logic [CX_W-1:0] x);
    return $signed({1'b0, x});
  endfunction

  function automatic logic signed [OP_W-1:0] ext_y(input logic [CY_W-1:0] y);
    return $signed({2'b00, y});
  endfunction

  function automatic logic signed [E_W-1:0] mul_ext(input logic signed [OP_W-1:0] a,
                                                    input logic signed [OP_W-1:0] b);
    logic signed [E_W-1:0] a_w;
    logic signed [E_W-1:0] b_w;
    a_w = E_W'(a);
    b_w = E_W'(b);
    return a_w * b_w;
  endfunction

  // (bx-ax)*(py-ay)
  function automatic logic signed [E_W-1:0] edge_p_ab(input vtx_t a, input vtx_t b,
                                                      input logic [CY_W-1:0] py);
    return mul_ext(ext_x(b.x) - ext_x(a.x), ext_y(py) - ext_y(a.y));
  endfunction

  // (px-ax)*(by-ay)
  function automatic logic signed [E_W-1:0] edge_p_pa(input vtx_t a, input vtx_t b,
                                                      input logic [CX_W-1:0] px);
    return mul_ext(ext_x(px) - ext_x(a.x), ext_y(b.y) - ext_y(a.y));
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running H/V counters with raw sync, active-region and frame-origin flags.
module vga_timing
  import vga_tri_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_ACT_START = DEF_H_ACT_START,
  parameter int H_ACT_END   = DEF_H_ACT_END,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_ACT_START = DEF_V_ACT_START,
  parameter int V_ACT_END   = DEF_V_ACT_END
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [CX_W-1:0] cx_o,
  output logic [CY_W-1:0] cy_o,
  output logic            hs_o,
  output logic            vs_o,
  output logic            active_o,
  output logic            origin_o
);

  localparam logic [CX_W-1:0] H_LAST  = CX_W'(H_TOTAL - 1);
  localparam logic [CX_W-1:0] H_SYN   = CX_W'(H_SYNC);
  localparam logic [CX_W-1:0] H_AS    = CX_W'(H_ACT_START);
  localparam logic [CX_W-1:0] H_AE    = CX_W'(H_ACT_END);
  localparam logic [CY_W-1:0] V_LAST  = CY_W'(V_TOTAL - 1);
  localparam logic [CY_W-1:0] V_SYN   = CY_W'(V_SYNC);
  localparam logic [CY_W-1:0] V_AS    = CY_W'(V_ACT_START);
  localparam logic [CY_W-1:0] V_AE    = CY_W'(V_ACT_END);

  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;

  // Next pixel position: cx wraps every line, cy advances on the cx wrap.
  always_comb begin
    cx_d = cx_q + 1'b1;
    cy_d = cy_q;
    if (cx_q == H_LAST) begin
      cx_d = '0;
      cy_d = (cy_q == V_LAST) ? '0 : cy_q + 1'b1;
    end
  end

  // Position registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx_o     = cx_q;
  assign cy_o     = cy_q;
  assign hs_o     = (cx_q >= H_SYN);
  assign vs_o     = (cy_q >= V_SYN);
  assign active_o = (cx_q >= H_AS) && (cx_q < H_AE) && (cy_q >= V_AS) && (cy_q < V_AE);
  assign origin_o = (cx_q == '0) && (cy_q == '0);

endmodule

// File: rtl/vga_tri_raster.sv
// VGA triangle rasteriser: shadow/active config banks, two-stage edge-function pipeline.
module vga_tri_raster
  import vga_tri_pkg::*;
#(
  parameter int          H_TOTAL     = DEF_H_TOTAL,
  parameter int          H_SYNC      = DEF_H_SYNC,
  parameter int          H_ACT_START = DEF_H_ACT_START,
  parameter int          H_ACT_END   = DEF_H_ACT_END,
  parameter int          V_TOTAL     = DEF_V_TOTAL,
  parameter int          V_SYNC      = DEF_V_SYNC,
  parameter int          V_ACT_START = DEF_V_ACT_START,
  parameter int          V_ACT_END   = DEF_V_ACT_END,
  parameter int          N_TRI       = 4,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_idx,
  input  logic [1:0]  cfg_field,
  input  logic [23:0] cfg_data,
  input  logic        cfg_commit,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        frame_start
);

  logic [CX_W-1:0] cx;
  logic [CY_W-1:0] cy;
  logic            hs_raw, vs_raw, active, origin;

  vga_timing #(
    .H_TOTAL    (H_TOTAL),
    .H_SYNC     (H_SYNC),
    .H_ACT_START(H_ACT_START),
    .H_ACT_END  (H_ACT_END),
    .V_TOTAL    (V_TOTAL),
    .V_SYNC     (V_SYNC),
    .V_ACT_START(V_ACT_START),
    .V_ACT_END  (V_ACT_END)
  ) u_timing (
    .clk_i   (CLOCK_50),
    .rst_ni  (RESET_N),
    .cx_o    (cx),
    .cy_o    (cy),
    .hs_o    (hs_raw),
    .vs_o    (vs_raw),
    .active_o(active),
    .origin_o(origin)
  );

  tri_t shadow_q [N_TRI];
  tri_t active_q [N_TRI];
  logic pending_q, pending_d;
  logic beat, latch;

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{cfg_data[23:22], cfg_data[11]};

  assign cfg_ready = ~pending_q;
  assign beat      = cfg_valid & cfg_ready;
  assign latch     = origin & pending_q;
  // Gated so the pulse is low while reset is held but present the moment it releases.
  assign frame_start = origin & RESET_N;

  // Commit request is held until the next frame origin; it blocks further beats meanwhile.
  always_comb begin
    pending_d = pending_q;
    if (latch)               pending_d = 1'b0;
    if (beat && cfg_commit)  pending_d = 1'b1;
  end

  // Pending-commit flag.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) pending_q <= 1'b0;
    else          pending_q <= pending_d;
  end

  // Shadow bank writes; indices beyond N_TRI never match and are dropped.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < N_TRI; i++) shadow_q[i] <= '0;
    end else if (beat) begin
      for (int i = 0; i < N_TRI; i++) begin
        if (cfg_idx == 3'(i)) begin
          case (cfg_field)
            FLD_V0:  shadow_q[i].v[0] <= '{x: cfg_data[10:0], y: cfg_data[21:12]};
            FLD_V1:  shadow_q[i].v[1] <= '{x: cfg_data[10:0], y: cfg_data[21:12]};
            FLD_V2:  shadow_q[i].v[2] <= '{x: cfg_data[10:0], y: cfg_data[21:12]};
            default: begin
              shadow_q[i].rgb <= cfg_data[11:0];
              shadow_q[i].en  <= cfg_data[12];
            end
          endcase
        end
      end
    end
  end

  // Active bank only changes at the frame origin, so a frame is never drawn from a mixed bank.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < N_TRI; i++) active_q[i] <= '0;
    end else if (latch) begin
      active_q <= shadow_q;
    end
  end

  logic [N_TRI-1:0] hit;
  logic [11:0]      col_s1 [N_TRI];

  for (genvar t = 0; t < N_TRI; t++) begin : g_tri
    vtx_t v0, v1, v2;
    logic signed [E_W-1:0] p_ab_q [3];
    logic signed [E_W-1:0] p_pa_q [3];
    logic signed [E_W-1:0] e0, e1, e2;
    logic                  en_s1_q;
    logic [11:0]           rgb_s1_q;
    logic                  all_le, all_ge;

    assign v0 = active_q[t].v[0];
    assign v1 = active_q[t].v[1];
    assign v2 = active_q[t].v[2];

    // Stage 1: both products of each edge function, plus this triangle's colour/enable.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        for (int e = 0; e < 3; e++) begin
          p_ab_q[e] <= '0;
          p_pa_q[e] <= '0;
        end
        en_s1_q  <= 1'b0;
        rgb_s1_q <= '0;
      end else begin
        p_ab_q[0] <= edge_p_ab(v0, v1, cy);
        p_pa_q[0] <= edge_p_pa(v0, v1, cx);
        p_ab_q[1] <= edge_p_ab(v1, v2, cy);
        p_pa_q[1] <= edge_p_pa(v1, v2, cx);
        p_ab_q[2] <= edge_p_ab(v2, v0, cy);
        p_pa_q[2] <= edge_p_pa(v2, v0, cx);
        en_s1_q   <= active_q[t].en;
        rgb_s1_q  <= active_q[t].rgb;
      end
    end

    assign e0 = p_ab_q[0] - p_pa_q[0];
    assign e1 = p_ab_q[1] - p_pa_q[1];
    assign e2 = p_ab_q[2] - p_pa_q[2];

    // Inclusive on edges and independent of winding: all non-positive or all non-negative.
    assign all_le = (e0[E_W-1] | ~|e0) & (e1[E_W-1] | ~|e1) & (e2[E_W-1] | ~|e2);
    assign all_ge = ~e0[E_W-1] & ~e1[E_W-1] & ~e2[E_W-1];

    assign hit[t]    = en_s1_q & (all_le | all_ge);
    assign col_s1[t] = rgb_s1_q;
  end

  logic        act_s1_q, hs_s1_q, vs_s1_q;
  logic [11:0] rgb_d, rgb_q;
  logic        hs_q, vs_q;

  // Stage 1 alignment of the per-pixel timing flags.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      act_s1_q <= 1'b0;
      hs_s1_q  <= 1'b0;
      vs_s1_q  <= 1'b0;
    end else begin
      act_s1_q <= active;
      hs_s1_q  <= hs_raw;
      vs_s1_q  <= vs_raw;
    end
  end

  // Priority colour select: scanning downward leaves the lowest covering index in place.
  always_comb begin
    rgb_d = '0;
    if (act_s1_q) begin
      rgb_d = BG_COLOR;
      for (int i = N_TRI - 1; i >= 0; i--) begin
        if (hit[i]) rgb_d = col_s1[i];
      end
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rgb_q <= '0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_s1_q;
      vs_q  <= vs_s1_q;
    end
  end

  assign VGA_R  = rgb_q[11:8];
  assign VGA_G  = rgb_q[7:4];
  assign VGA_B  = rgb_q[3:0];
  assign VGA_HS = hs_q;
  assign VGA_VS = vs_q;

endmodule

// File: tb/tb_vga_tri_raster.sv
// Directed bench for vga_tri_raster on a shrunken 40x24 raster.
module tb_vga_tri_raster;

  localparam int HT = 40;
  localparam int VT = 24;
  localparam int FR = HT * VT;
  localparam logic [11:0] BG = 12'h00F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_commit = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [1:0]  cfg_field = '0;
  logic [23:0] cfg_data = '0;
  logic        cfg_ready;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start;
  logic [11:0] rgb;

  int n_cmp  = 0;
  int n_fail = 0;

  assign rgb = {vga_r, vga_g, vga_b};

  vga_tri_raster #(
    .H_TOTAL(HT), .H_SYNC(4), .H_ACT_START(6), .H_ACT_END(36),
    .V_TOTAL(VT), .V_SYNC(2), .V_ACT_START(3), .V_ACT_END(22),
    .N_TRI(4), .BG_COLOR(BG)
  ) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_idx    (cfg_idx),
    .cfg_field  (cfg_field),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .VGA_R      (vga_r),
    .VGA_G      (vga_g),
    .VGA_B      (vga_b),
    .VGA_HS     (vga_hs),
    .VGA_VS     (vga_vs),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] vtx(input int x, input int y);
    logic [23:0] d;
    d = '0;
    d[10:0]  = x[10:0];
    d[21:12] = y[9:0];
    return d;
  endfunction

  function automatic logic [23:0] colw(input logic [11:0] c, input logic en);
    return {11'b0, en, c};
  endfunction

  // Returns at the negedge of the origin cycle (cx=0, cy=0).
  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 3 * FR);
    if (!frame_start) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_fs: frame_start=%0b after %0d cycles, need 1", frame_start, n);
    end
  endtask

  task automatic cfg_beat(input int idx, input int field, input logic [23:0] data, input logic commit);
    int n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 3 * FR) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL cfg_ready_wait: cfg_ready=%0b after %0d cycles, need 1", cfg_ready, n);
    end
    cfg_valid  = 1'b1;
    cfg_idx    = idx[2:0];
    cfg_field  = field[1:0];
    cfg_data   = data;
    cfg_commit = commit;
    @(negedge clk);
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic load_tri(input int idx, input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input logic [11:0] c, input logic en,
                          input logic commit);
    cfg_beat(idx, 0, vtx(x0, y0), 1'b0);
    cfg_beat(idx, 1, vtx(x1, y1), 1'b0);
    cfg_beat(idx, 2, vtx(x2, y2), 1'b0);
    cfg_beat(idx, 3, colw(c, en), commit);
  endtask

  // Pixel (x,y) appears two cycles after the counters reach it.
  task automatic sample_px(input int x, input int y, output logic [11:0] v);
    wait_fs();
    repeat (y * HT + x + 2) @(negedge clk);
    v = rgb;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (57) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL rst_rgb: got %h need 000", rgb); end
    n_cmp++; if (vga_hs !== 1'b0) begin n_fail++; $display("FAIL rst_hs: got %b need 0", vga_hs); end
    n_cmp++; if (vga_vs !== 1'b0) begin n_fail++; $display("FAIL rst_vs: got %b need 0", vga_vs); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b need 1", cfg_ready); end
    n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_fs_held: got %b need 0", frame_start); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_cmp++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL rst_fs_release: got %b need 1", frame_start); end
    n_cmp++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL rel_rgb: got %h need 000", rgb); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b need 1", cfg_ready); end
  endtask

  task automatic test_timing();
    int pos, x, y;
    logic [11:0] e_rgb;
    logic e_hs, e_vs, e_fs;
    wait_fs();
    for (int c = 1; c <= FR + 1; c++) begin
      @(negedge clk);
      pos   = (c - 2 + FR) % FR;
      x     = pos % HT;
      y     = pos / HT;
      e_rgb = (x >= 6 && x < 36 && y >= 3 && y < 22) ? BG : 12'h000;
      e_hs  = (x >= 4);
      e_vs  = (y >= 2);
      e_fs  = (c == FR);
      n_cmp++; if (rgb !== e_rgb) begin n_fail++; $display("FAIL tim_rgb c=%0d: got %h need %h", c, rgb, e_rgb); end
      n_cmp++; if (vga_hs !== e_hs) begin n_fail++; $display("FAIL tim_hs c=%0d: got %b need %b", c, vga_hs, e_hs); end
      n_cmp++; if (vga_vs !== e_vs) begin n_fail++; $display("FAIL tim_vs c=%0d: got %b need %b", c, vga_vs, e_vs); end
      n_cmp++; if (frame_start !== e_fs) begin n_fail++; $display("FAIL tim_fs c=%0d: got %b need %b", c, frame_start, e_fs); end
    end
  endtask

  task automatic test_single();
    int          px [6] = '{15, 25, 20, 31, 10, 2};
    int          py [6] = '{10, 18,  5,  5, 20, 1};
    logic [11:0] ex [6] = '{12'hCCC, BG, 12'hCCC, BG, 12'hCCC, 12'h000};
    logic [11:0] v;
    load_tri(0, 10, 5, 30, 5, 10, 20, 12'hCCC, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      sample_px(px[i], py[i], v);
      n_cmp++; if (v !== ex[i]) begin n_fail++; $display("FAIL single_fwd (%0d,%0d): got %h need %h", px[i], py[i], v, ex[i]); end
    end
    load_tri(0, 10, 20, 30, 5, 10, 5, 12'hCCC, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      sample_px(px[i], py[i], v);
      n_cmp++; if (v !== ex[i]) begin n_fail++; $display("FAIL single_rev (%0d,%0d): got %h need %h", px[i], py[i], v, ex[i]); end
    end
  endtask

  task automatic test_priority();
    logic [11:0] v;
    load_tri(0, 10, 5, 30, 5, 10, 20, 12'hF00, 1'b1, 1'b0);
    load_tri(1, 12, 8, 34, 8, 12, 21, 12'h0F0, 1'b1, 1'b1);
    sample_px(15, 10, v);
    n_cmp++; if (v !== 12'hF00) begin n_fail++; $display("FAIL prio_overlap: got %h need F00", v); end
    sample_px(20, 15, v);
    n_cmp++; if (v !== 12'h0F0) begin n_fail++; $display("FAIL prio_only1: got %h need 0F0", v); end
    sample_px(11, 18, v);
    n_cmp++; if (v !== 12'hF00) begin n_fail++; $display("FAIL prio_only0: got %h need F00", v); end
    cfg_beat(0, 3, colw(12'hF00, 1'b0), 1'b1);
    sample_px(15, 10, v);
    n_cmp++; if (v !== 12'h0F0) begin n_fail++; $display("FAIL prio_dis0_overlap: got %h need 0F0", v); end
    sample_px(11, 18, v);
    n_cmp++; if (v !== BG) begin n_fail++; $display("FAIL prio_dis0_only0: got %h need %h", v, BG); end
  endtask

  task automatic test_commit_timing();
    int bad = 0;
    wait_fs();
    repeat (12 * HT) @(negedge clk);
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ct_ready_before: got %b need 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_idx = 3'd0; cfg_field = 2'd3; cfg_data = colw(12'h0AA, 1'b1); cfg_commit = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL ct_ready_after: got %b need 0", cfg_ready); end
    repeat (733 - 481) @(negedge clk);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL ct_cur_frame: got %h need %h", rgb, BG); end
    for (int c = 734; c < FR; c++) begin
      @(negedge clk);
      if (cfg_ready !== 1'b0 || frame_start !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL ct_hold: got %0d bad cycles need 0", bad); end
    @(negedge clk);
    n_cmp++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL ct_fs: got %b need 1", frame_start); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL ct_ready_origin: got %b need 0", cfg_ready); end
    @(negedge clk);
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ct_ready_next: got %b need 1", cfg_ready); end
    repeat (732) @(negedge clk);
    n_cmp++; if (rgb !== 12'h0AA) begin n_fail++; $display("FAIL ct_new_frame: got %h need 0AA", rgb); end
  endtask

  task automatic test_edges();
    logic [11:0] v;
    load_tri(7, 6, 3, 35, 3, 6, 21, 12'hFFF, 1'b1, 1'b1);
    sample_px(8, 5, v);
    n_cmp++; if (v !== BG) begin n_fail++; $display("FAIL idx7_ignored: got %h need %h", v, BG); end
    sample_px(20, 15, v);
    n_cmp++; if (v !== 12'h0F0) begin n_fail++; $display("FAIL idx7_keep1: got %h need 0F0", v); end
    load_tri(2, 6, 3, 35, 3, 6, 21, 12'hFFF, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rp_pending: got %b need 0", cfg_ready); end
    #2 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rp_ready: got %b need 1", cfg_ready); end
    sample_px(15, 10, v);
    n_cmp++; if (v !== BG) begin n_fail++; $display("FAIL rp_px_15_10: got %h need %h", v, BG); end
    sample_px(8, 5, v);
    n_cmp++; if (v !== BG) begin n_fail++; $display("FAIL rp_px_8_5: got %h need %h", v, BG); end
    sample_px(20, 15, v);
    n_cmp++; if (v !== BG) begin n_fail++; $display("FAIL rp_px_20_15: got %h need %h", v, BG); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_single();
    test_priority();
    test_commit_timing();
    test_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
